paralelo_serie_tx: RTL

//   Transmit side of the phy serial link: turns 8-bit parallel bytes into one bit per clk_8f.

---
 rtl/phy_pkg.sv | 15 +
 rtl/paralelo_serie_tx_fifo.sv | 63 ++++++
 rtl/paralelo_serie_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the phy serial link.
//   PHY_COMMA      : idle / sync byte on the serial line
//   PHY_SYNC_COUNT : commas sent after reset before user data is allowed out
//   tx_state_e     : transmit FSM state (SYNC while locking the receiver, RUN afterwards)
package phy_pkg;

  localparam logic [7:0]  PHY_COMMA      = 8'hBC;
  localparam int unsigned PHY_SYNC_COUNT = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/paralelo_serie_tx_fifo.sv
// tx_byte_fifo: small synchronous FIFO buffering bytes in front of the serialiser.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  synchronous active-low reset; flushes the queue
//   i_push  in  write i_din (ignored while full)
//   i_din   in  DATA_W data to write
//   i_pop   in  discard the head entry (ignored while empty)
//   o_head  out oldest entry, valid while o_empty==0
//   o_full  out DEPTH entries stored
//   o_empty out no entries stored
// Simultaneous push and pop keeps the count; the pop returns the old head.
module tx_byte_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/paralelo_serie_tx.sv
// paralelo_serie_tx: transmit side of the phy serial link. Serialises bytes MSB first,
// one bit per clk_8f. After reset it sends SYNC_COUNT commas, then user data; the line
// is filled with commas whenever no byte is queued.
// Ports:
//   clk_8f      in  bit clock, rising edge
//   reset       in  synchronous active-low reset
//   data_in     in  byte to transmit
//   valid_in    in  data_in valid; accepted when valid_in && ready_out
//   ready_out   out input buffer has room (0 while reset is asserted)
//   data_out    out registered serial bit
//   byte_strobe out 1 while data_out carries bit 7 of a byte
//   active      out 1 once sync is complete
module paralelo_serie_tx
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA      = PHY_COMMA,
  parameter int unsigned SYNC_COUNT = PHY_SYNC_COUNT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_strobe,
  output logic       active
);

  logic [2:0] r_bit_cnt;
  tx_state_e  r_state;
  logic [3:0] r_sync_cnt;
  logic [7:0] r_hold;
  logic       r_data_out;
  logic       r_strobe;
  logic       r_active;

  logic       w_select;
  logic       w_sync_done;
  logic       w_run;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic [7:0] w_nxt;

  assign w_select    = (r_bit_cnt == 3'd7);
  assign w_sync_done = (r_sync_cnt == 4'(SYNC_COUNT));
  // The select that completes sync already counts as RUN so it can take user data.
  assign w_run       = (r_state == RUN) || w_sync_done;
  assign w_pop       = w_select && w_run && !w_empty;
  assign w_nxt       = w_pop ? w_head : COMMA;
  assign ready_out   = reset && !w_full;
  assign w_push      = valid_in && ready_out;

  tx_byte_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_8f),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_din   (data_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      r_bit_cnt  <= 3'd7;
      r_state    <= SYNC;
      r_sync_cnt <= '0;
      r_hold     <= '0;
      r_data_out <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_bit_cnt <= r_bit_cnt - 3'd1;
      if (w_select) begin
        r_hold     <= w_nxt;
        r_data_out <= w_nxt[7];
        r_strobe   <= 1'b1;
        if (r_state == SYNC) begin
          if (w_sync_done) begin
            r_state  <= RUN;
            r_active <= 1'b1;
          end else if (r_sync_cnt < 4'(SYNC_COUNT)) begin
            r_sync_cnt <= r_sync_cnt + 4'd1;
          end
        end
      end else begin
        r_data_out <= r_hold[r_bit_cnt];
        r_strobe   <= 1'b0;
      end
    end
  end

  assign data_out    = r_data_out;
  assign byte_strobe = r_strobe;
  assign active      = r_active;

endmodule
